// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Optional MDU_FAST_MUL_EN: single-cycle array multiply; divides stay iterative.
module mult_div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic                  hi_write,
   input  logic                  lo_write,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  busy,
   output logic                  done,
   output logic                  div_by_zero,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

   state_t          state;
   logic            is_mul;
   logic            is_dz;
   logic            neg_q;
   logic            neg_r;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [2*W-1:0]  acc;
   logic [CW-1:0]   cnt;

   logic [W-1:0]    a_mag;
   logic [W-1:0]    b_mag;
   logic [W:0]      mul_sum;
   logic [W:0]      rem_shift;
   logic [W:0]      rem_diff;
   logic            q_bit;
   logic [W-1:0]    rem_next;
   logic [2*W-1:0]  prod_fix;
   logic [W-1:0]    res_hi;
   logic [W-1:0]    res_lo;
`ifdef MDU_FAST_MUL_EN
   logic [2*W-1:0]  fast_prod;
`endif

   assign busy = (state != IDLE);

   // op[0] selects signed; the magnitude of the most negative value wraps to itself, as intended.
   assign a_mag = (op[0] && operand_a[W-1]) ? -operand_a : operand_a;
   assign b_mag = (op[0] && operand_b[W-1]) ? -operand_b : operand_b;

`ifdef MDU_FAST_MUL_EN
   assign fast_prod = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
`endif

   // Multiply: add into the upper half, then shift the whole accumulator right.
   assign mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (b_reg[0] ? a_reg : {W{1'b0}})};

   // Divide: remainder lives in acc upper half, quotient shifts into the lower half.
   assign rem_shift = {acc[2*W-1:W], a_reg[W-1]};
   assign rem_diff  = rem_shift - {1'b0, b_reg};
   assign q_bit     = ~rem_diff[W];
   assign rem_next  = q_bit ? rem_diff[W-1:0] : rem_shift[W-1:0];

   // NOTE: every variable assigned in this block gets a default first, so no latch can be inferred.
   always_comb begin
      prod_fix = neg_q ? -acc : acc;
      res_hi   = acc[2*W-1:W];
      res_lo   = acc[W-1:0];
      if (is_dz) begin
         res_hi = acc[2*W-1:W];
         res_lo = acc[W-1:0];
      end else if (is_mul) begin
         res_hi = prod_fix[2*W-1:W];
         res_lo = prod_fix[W-1:0];
      end else begin
         if (neg_r) res_hi = -acc[2*W-1:W];
         if (neg_q) res_lo = -acc[W-1:0];
      end
   end

   // NOTE: reset is synchronous and clears all state, so an abandoned operation leaves no trace.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         is_mul      <= 1'b0;
         is_dz       <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         a_reg       <= '0;
         b_reg       <= '0;
         acc         <= '0;
         cnt         <= '0;
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_mul <= ~op[1];
                  is_dz  <= 1'b0;
                  neg_q  <= op[0] & (operand_a[W-1] ^ operand_b[W-1]);
                  neg_r  <= op[0] & operand_a[W-1];
                  a_reg  <= a_mag;
                  b_reg  <= b_mag;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= CALC;
                  if (op[1] && operand_b == '0) begin
                     // Divide by zero skips CALC; the final result is staged in acc.
                     is_dz <= 1'b1;
                     acc   <= {operand_a, {W{1'b1}}};
                     state <= FIXUP;
                  end
`ifdef MDU_FAST_MUL_EN
                  else if (!op[1]) begin
                     acc   <= fast_prod;
                     state <= FIXUP;
                  end
`endif
               end else begin
                  if (hi_write) hi <= write_data;
                  if (lo_write) lo <= write_data;
               end
            end
            CALC: begin
               if (is_mul) begin
                  acc   <= {mul_sum, acc[W-1:1]};
                  b_reg <= b_reg >> 1;
               end else begin
                  acc   <= {rem_next, acc[W-2:0], q_bit};
                  a_reg <= a_reg << 1;
               end
               cnt <= cnt + CW'(1);
               if (cnt == CW'(W-1)) state <= FIXUP;
            end
            FIXUP: begin
               hi          <= res_hi;
               lo          <= res_lo;
               done        <= 1'b1;
               div_by_zero <= is_dz;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
